// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned NUM_BTNS            = 4;

  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_STOP  = 1;
  localparam int unsigned BTN_CLEAR = 2;
  localparam int unsigned BTN_LAP   = 3;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: synchronizer, stability counter and one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Accepted level moves only after the synced level has differed for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, btn});
      press  <= 1'b0;
      if (synced == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        level_q <= synced;
        press   <= synced;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap sequencer with debounced buttons and gated count enable.
// Optional: define STOPWATCH_AUTO_STOP_EN to stop at 9999 instead of rolling over.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       tick,
  input  logic       wrap,
  output logic       count_en,
  output logic       clear,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;

  assign btn_raw[BTN_START] = btn_start;
  assign btn_raw[BTN_STOP]  = btn_stop;
  assign btn_raw[BTN_CLEAR] = btn_clear;
  assign btn_raw[BTN_LAP]   = btn_lap;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  logic auto_stop;
  logic start_block;

`ifdef STOPWATCH_AUTO_STOP_EN
  assign auto_stop   = wrap & tick;
  assign start_block = wrap;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign auto_stop   = 1'b0;
  assign start_block = 1'b0;
`endif

  state_e state_q;
  state_e state_n;
  logic   advancing;
  logic   count_en_n;
  logic   clear_n;
  logic   freeze_n;

  assign advancing = (state_q == RUN) || (state_q == LAP);

  // Next state: clear > auto-stop > stop > start > lap; lower presses are dropped.
  always_comb begin
    state_n    = state_q;
    clear_n    = 1'b0;
    count_en_n = tick & advancing & ~press[BTN_CLEAR] & ~auto_stop;
    if (press[BTN_CLEAR]) begin
      state_n = IDLE;
      clear_n = 1'b1;
    end else if (advancing && auto_stop) begin
      state_n = PAUSE;
    end else if (press[BTN_STOP]) begin
      if (advancing) state_n = PAUSE;
    end else if (press[BTN_START]) begin
      if (state_q == IDLE || (state_q == PAUSE && !start_block)) state_n = RUN;
    end else if (press[BTN_LAP]) begin
      case (state_q)
        RUN:     state_n = LAP;
        LAP:     state_n = RUN;
        default: state_n = state_q;
      endcase
    end
    freeze_n = (state_n == LAP) || ((state_n == PAUSE) && freeze);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_en <= 1'b0;
      clear    <= 1'b0;
      freeze   <= 1'b0;
      running  <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_en <= count_en_n;
      clear    <= clear_n;
      freeze   <= freeze_n;
      running  <= (state_n == RUN) || (state_n == LAP);
    end
  end

  assign state = 2'(state_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and randomized checks of stopwatch_ctrl against a behavioural model.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned DC = 4;
  localparam int unsigned SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_v;
  logic       tick_v;
  logic       wrap_v;
  logic       count_en, clear, freeze, running;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_start(btn_v[0]),
    .btn_stop (btn_v[1]),
    .btn_clear(btn_v[2]),
    .btn_lap  (btn_v[3]),
    .tick     (tick_v),
    .wrap     (wrap_v),
    .count_en (count_en),
    .clear    (clear),
    .freeze   (freeze),
    .running  (running),
    .state    (state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int gcnt  = 0;
  logic wrap_lvl = 1'b0;

  // Model: transition table [state][button], debounce by consecutive-cycle run length.
  int   nxt_tbl [4][4];
  int   m_state;
  bit   m_freeze;
  bit   [3:0] m_pend;
  bit   [3:0] m_acc;
  int   m_run [4];
  bit   m_sh [4][SS];
  logic [1:0] e_state;
  logic e_count_en, e_clear, e_freeze, e_running;

  task automatic model_reset();
    m_state = 0; m_freeze = 0; m_pend = '0; m_acc = '0;
    for (int b = 0; b < 4; b++) begin
      m_run[b] = 0;
      for (int s = 0; s < SS; s++) m_sh[b][s] = 1'b0;
    end
    e_state = 2'd0; e_count_en = 0; e_clear = 0; e_freeze = 0; e_running = 0;
  endtask

  task automatic model_edge();
    int act;
    int nxt;
    bit wstop;
    bit synced;
    bit [3:0] newp;
    act = -1;
    if (m_pend[2]) act = 2;
    else if (m_pend[1]) act = 1;
    else if (m_pend[0]) act = 0;
    else if (m_pend[3]) act = 3;
    nxt = (act >= 0) ? nxt_tbl[m_state][act] : m_state;
    wstop = 1'b0;
`ifdef STOPWATCH_AUTO_STOP_EN
    if (act != 2 && tick_v && wrap_v && (m_state == 1 || m_state == 3)) begin
      nxt = 2; wstop = 1'b1;
    end
    if (m_state == 2 && act == 0 && wrap_v) nxt = 2;
`endif
    e_count_en = tick_v && (m_state == 1 || m_state == 3) && act != 2 && !wstop;
    e_clear    = (act == 2);
    m_freeze   = (nxt == 3) || (nxt == 2 && m_freeze);
    m_state    = nxt;
    e_state    = 2'(nxt);
    e_freeze   = m_freeze;
    e_running  = (nxt == 1) || (nxt == 3);
    newp = '0;
    for (int b = 0; b < 4; b++) begin
      synced = m_sh[b][SS-1];
      if (synced != m_acc[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_acc[b] = synced; newp[b] = synced; m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      for (int s = SS - 1; s > 0; s--) m_sh[b][s] = m_sh[b][s-1];
      m_sh[b][0] = btn_v[b];
    end
    m_pend = newp;
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (state === e_state) else begin
      n_err++; $error("FAIL %s state: got %0d expected %0d", tag, state, e_state);
    end
    n_cmp++;
    assert (count_en === e_count_en) else begin
      n_err++; $error("FAIL %s count_en: got %b expected %b", tag, count_en, e_count_en);
    end
    n_cmp++;
    assert (clear === e_clear) else begin
      n_err++; $error("FAIL %s clear: got %b expected %b", tag, clear, e_clear);
    end
    n_cmp++;
    assert (freeze === e_freeze) else begin
      n_err++; $error("FAIL %s freeze: got %b expected %b", tag, freeze, e_freeze);
    end
    n_cmp++;
    assert (running === e_running) else begin
      n_err++; $error("FAIL %s running: got %b expected %b", tag, running, e_running);
    end
  endtask

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] b, input logic t, input logic w, input string tag);
    btn_v = b; tick_v = t; wrap_v = w;
    @(posedge clk);
    model_edge();
    gcnt++;
    @(negedge clk);
    check(tag);
  endtask

  task automatic hold(input logic [3:0] b, input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(b, (gcnt % 10) == 0, wrap_lvl, tag);
  endtask

  task automatic press(input logic [3:0] b, input string tag);
    hold(b, 8, tag);
    hold(4'b0000, 10, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_state"}, int'(state), 0);
    expect_eq({tag, "_count_en"}, int'(count_en), 0);
    expect_eq({tag, "_clear"}, int'(clear), 0);
    expect_eq({tag, "_freeze"}, int'(freeze), 0);
    expect_eq({tag, "_running"}, int'(running), 0);
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 4; b++) nxt_tbl[s][b] = s;
    nxt_tbl[0][0] = 1; nxt_tbl[0][2] = 0;
    nxt_tbl[1][1] = 2; nxt_tbl[1][3] = 3; nxt_tbl[1][2] = 0;
    nxt_tbl[2][0] = 1; nxt_tbl[2][2] = 0;
    nxt_tbl[3][3] = 1; nxt_tbl[3][1] = 2; nxt_tbl[3][2] = 0;

    btn_v = '0; tick_v = 1'b0; wrap_v = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Short start glitch is filtered out.
    hold(4'b0001, 3, "glitch");
    hold(4'b0000, 12, "glitch_idle");
    expect_eq("glitch_state", int'(state), 0);

    // Start held: RUN on the 7th edge after the press.
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b0001, (gcnt % 10) == 0, 1'b0, "start");
      if (i == 6) expect_eq("start_pre", int'(state), 0);
      if (i == 7) expect_eq("start_run", int'(state), 1);
    end
    hold(4'b0000, 20, "run");
    expect_eq("run_running", int'(running), 1);

    // Lap view sequences.
    press(4'b1000, "lap1");
    expect_eq("lap1_state", int'(state), 3);
    expect_eq("lap1_freeze", int'(freeze), 1);
    press(4'b1000, "lap2");
    expect_eq("lap2_state", int'(state), 1);
    expect_eq("lap2_freeze", int'(freeze), 0);
    press(4'b1000, "lap3");
    press(4'b0010, "lap_stop");
    expect_eq("lap_stop_state", int'(state), 2);
    expect_eq("lap_stop_freeze", int'(freeze), 1);
    press(4'b0001, "resume");
    expect_eq("resume_state", int'(state), 1);
    expect_eq("resume_freeze", int'(freeze), 0);

    // Clear and stop accepted together, with a tick in the same cycle.
    for (int i = 0; i < 6; i++) cyc(4'b0110, 1'b0, 1'b0, "clr_stop");
    cyc(4'b0110, 1'b1, 1'b0, "clr_stop_act");
    expect_eq("clr_stop_state", int'(state), 0);
    expect_eq("clr_stop_pulse", int'(clear), 1);
    expect_eq("clr_stop_cnt", int'(count_en), 0);
    cyc(4'b0110, 1'b0, 1'b0, "clr_stop_after");
    expect_eq("clr_stop_pulse_end", int'(clear), 0);
    hold(4'b0000, 10, "clr_stop_rel");

    // Asynchronous reset mid-RUN with start held.
    press(4'b0001, "pre_reset");
    hold(4'b0001, 3, "hold_start");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(4'b0001, 1'b0, 1'b0, "post_reset");
      if (i == 6) expect_eq("post_reset_pre", int'(state), 0);
      if (i == 7) expect_eq("post_reset_run", int'(state), 1);
    end
    hold(4'b0000, 10, "post_reset_rel");

    // Wrap with a tick while running.
    cyc(4'b0000, 1'b1, 1'b1, "wrap_tick");
`ifdef STOPWATCH_AUTO_STOP_EN
    expect_eq("wrap_cnt", int'(count_en), 0);
    expect_eq("wrap_state", int'(state), 2);
`else
    expect_eq("wrap_cnt", int'(count_en), 1);
    expect_eq("wrap_state", int'(state), 1);
`endif
    wrap_lvl = 1'b1;
    press(4'b0001, "wrap_start");
`ifdef STOPWATCH_AUTO_STOP_EN
    expect_eq("wrap_start_state", int'(state), 2);
`else
    expect_eq("wrap_start_state", int'(state), 1);
`endif
    hold(4'b0100, 7, "wrap_clear");
    expect_eq("wrap_clear_pulse", int'(clear), 1);
    expect_eq("wrap_clear_state", int'(state), 0);
    hold(4'b0000, 10, "wrap_clear_rel");
    wrap_lvl = 1'b0;

    // Randomized button activity, ticks and wrap.
    for (int ev = 0; ev < 60; ev++) begin
      logic [3:0] m;
      int hl;
      int gp;
      m  = 4'($urandom_range(1, 15));
      hl = int'($urandom_range(1, 12));
      gp = int'($urandom_range(1, 12));
      for (int i = 0; i < hl; i++)
        cyc(m, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), "rand_hold");
      for (int i = 0; i < gp; i++)
        cyc(4'b0000, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), "rand_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
